// File: rtl/pt_feedback_pkg.sv
// Shared definitions for the optical-trap release sequencer: FSM state encoding and
// the minimum spacing between successive trigger pulses.
package pt_feedback_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StPulse,
    StWait,
    StDone
  } seq_state_e;

  // Triggers are never closer than this, so trig_o cannot be high on adjacent cycles.
  localparam int unsigned MinPeriod = 2;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module cycle_down_counter #(
  parameter int unsigned COUNTER_WIDTH = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic [COUNTER_WIDTH-1:0] load_val_i,
  input  logic                     dec_i,
  output logic                     zero_o
);

  logic [COUNTER_WIDTH-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (dec_i && (r_count != '0)) begin
      r_count <= r_count - COUNTER_WIDTH'(1);
    end
  end

  assign zero_o = (r_count == '0);

endmodule

// File: rtl/optical_trap_release_seq.sv
// Release sequencer: after a start, waits a pre-delay, then issues num_pulses one-cycle
// triggers spaced by the period. Define OPTICAL_TRAP_SEQ_EXT_TRIG_EN to pace triggers
// from rising edges of ext_trig_i instead of the period count.
module optical_trap_release_seq
  import pt_feedback_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH   = 18,
  parameter int unsigned PULSE_CNT_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       trap_hold_i,
  input  logic [COUNTER_WIDTH-1:0]   pre_cycles_i,
  input  logic [COUNTER_WIDTH-1:0]   period_cycles_i,
  input  logic [PULSE_CNT_WIDTH-1:0] num_pulses_i,
`ifdef OPTICAL_TRAP_SEQ_EXT_TRIG_EN
  input  logic                       ext_trig_i,
`endif
  output logic                       trig_o,
  output logic                       trap_enable_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_o
);

  seq_state_e                 r_state;
  seq_state_e                 w_state_d;
  logic [PULSE_CNT_WIDTH-1:0] r_num;
  logic [PULSE_CNT_WIDTH-1:0] r_pulse_cnt;
  logic                       r_trap_en;

  logic                       w_accept;
  logic                       w_pulse_inc;
  logic                       w_cnt_load;
  logic                       w_cnt_dec;
  logic [COUNTER_WIDTH-1:0]   w_cnt_val;
  logic                       w_cnt_zero;
  logic [PULSE_CNT_WIDTH:0]   w_cnt_plus;
  logic                       w_last_pulse;
  seq_state_e                 w_first_trig_st;

`ifdef OPTICAL_TRAP_SEQ_EXT_TRIG_EN
  logic r_ext_q;
  logic w_ext_rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ext_q <= 1'b0;
    end else begin
      r_ext_q <= ext_trig_i;
    end
  end

  assign w_ext_rise      = ext_trig_i & ~r_ext_q;
  // Every trigger, including the first, waits for an external edge.
  assign w_first_trig_st = StWait;
`else
  logic [COUNTER_WIDTH-1:0] r_period;
  logic [COUNTER_WIDTH-1:0] w_period_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_period <= '0;
    end else if (w_accept) begin
      r_period <= period_cycles_i;
    end
  end

  // PULSE plus (load + 1) WAIT cycles gives a spacing of max(period, MinPeriod).
  assign w_period_load   = (r_period < COUNTER_WIDTH'(MinPeriod)) ? '0 :
                           r_period - COUNTER_WIDTH'(MinPeriod);
  assign w_first_trig_st = StPulse;
`endif

  assign w_cnt_plus   = {1'b0, r_pulse_cnt} + (PULSE_CNT_WIDTH + 1)'(1);
  assign w_last_pulse = (w_cnt_plus >= {1'b0, r_num});

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_pulse_inc = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_val   = '0;
    case (r_state)
      StIdle: begin
        if (start_i && !abort_i) begin
          w_accept = 1'b1;
          if (num_pulses_i == '0) begin
            w_state_d = StDone;
          end else if (pre_cycles_i != '0) begin
            // The pre delay lives only in the counter; it is the latched copy.
            w_state_d  = StPre;
            w_cnt_load = 1'b1;
            w_cnt_val  = pre_cycles_i - COUNTER_WIDTH'(1);
          end else begin
            w_state_d = w_first_trig_st;
          end
        end
      end
      StPre: begin
        if (w_cnt_zero) begin
          w_state_d = w_first_trig_st;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      StPulse: begin
        w_pulse_inc = 1'b1;
        if (w_last_pulse) begin
          w_state_d = StDone;
        end else begin
          w_state_d = StWait;
`ifndef OPTICAL_TRAP_SEQ_EXT_TRIG_EN
          w_cnt_load = 1'b1;
          w_cnt_val  = w_period_load;
`endif
        end
      end
      StWait: begin
`ifdef OPTICAL_TRAP_SEQ_EXT_TRIG_EN
        if (w_ext_rise) begin
          w_state_d = StPulse;
        end
`else
        if (w_cnt_zero) begin
          w_state_d = StPulse;
        end else begin
          w_cnt_dec = 1'b1;
        end
`endif
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    if (abort_i && (r_state != StIdle)) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_num       <= '0;
      r_pulse_cnt <= '0;
      r_trap_en   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_trap_en <= busy_o | trap_hold_i;
      if (w_accept) begin
        r_num       <= num_pulses_i;
        r_pulse_cnt <= '0;
      end else if (w_pulse_inc && (r_pulse_cnt != '1)) begin
        // A trigger already issued is counted even if abort arrives in its cycle.
        r_pulse_cnt <= r_pulse_cnt + PULSE_CNT_WIDTH'(1);
      end
    end
  end

  cycle_down_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_delay_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (w_cnt_load),
    .load_val_i(w_cnt_val),
    .dec_i     (w_cnt_dec),
    .zero_o    (w_cnt_zero)
  );

  assign trig_o        = (r_state == StPulse);
  assign busy_o        = (r_state != StIdle);
  assign done_o        = (r_state == StDone);
  assign pulse_cnt_o   = r_pulse_cnt;
  assign trap_enable_o = r_trap_en;

endmodule

// File: doc/optical_trap_release_seq.md
OPTICAL_TRAP_RELEASE_SEQ -- requirements
Module: optical_trap_release_seq

Interface
REQ-001 Parameter COUNTER_WIDTH, default 18: width of the delay and period cycle counters.
REQ-002 Parameter PULSE_CNT_WIDTH, default 8: width of the pulse-count configuration and status.
REQ-003 clk_i  in  1  single clock; all logic SHALL be rising-edge clocked on clk_i.
REQ-004 rst_i  in  1  reset; SHALL be synchronous and active-high.
REQ-005 start_i  in  1  request to begin one release sequence.
REQ-006 abort_i  in  1  terminate the sequence immediately.
REQ-007 trap_hold_i  in  1  keep the trap enabled while idle.
REQ-008 pre_cycles_i  in  COUNTER_WIDTH  delay from start to the first trigger.
REQ-009 period_cycles_i  in  COUNTER_WIDTH  spacing between successive triggers.
REQ-010 num_pulses_i  in  PULSE_CNT_WIDTH  number of triggers per sequence.
REQ-011 trig_o  out  1  one-cycle trigger to the downstream triggered-toggle datapath.
REQ-012 trap_enable_o  out  1  enable for the downstream trap output mux.
REQ-013 busy_o  out  1  high from start acceptance until return to IDLE.
REQ-014 done_o  out  1  one-cycle pulse on normal completion.
REQ-015 pulse_cnt_o  out  PULSE_CNT_WIDTH  triggers issued in the current or last sequence.

Function
REQ-016 FSM states SHALL be IDLE, PRE, PULSE, WAIT and DONE.
REQ-017 start_i SHALL be accepted only in IDLE; it SHALL be ignored in every other state.
REQ-018 On acceptance, the pre, period and num configuration SHALL be latched; later input changes SHALL NOT affect the running sequence.
REQ-019 Acceptance at edge k SHALL produce the first trig_o high in cycle k+1+pre_cycles (PRE lasts pre_cycles cycles, possibly 0).
REQ-020 Successive trig_o pulses SHALL be spaced max(period_cycles,2) cycles, so trig_o is never high on two consecutive cycles.
REQ-021 pulse_cnt_o SHALL clear on acceptance and SHALL increment in the cycle after each trig_o pulse.
REQ-022 After the num-th trigger, the FSM SHALL enter DONE for exactly one cycle with done_o=1, then return to IDLE.
REQ-023 If num_pulses=0, acceptance SHALL go directly to DONE: no trig_o, done_o one cycle later.
REQ-024 abort_i in any non-IDLE state SHALL force IDLE on the next edge, with trig_o=0 and done_o not asserted; pulse_cnt_o SHALL hold its value.
REQ-025 abort_i and start_i together in IDLE: abort SHALL win and the start SHALL NOT be accepted.
REQ-026 trap_enable_o SHALL be registered and equal busy_o OR trap_hold_i of the previous cycle.
REQ-027 Counters SHALL count down to zero without wrap; pulse_cnt SHALL saturate at all-ones.

Reset
REQ-028 rst_i high SHALL force IDLE on the next edge, overriding abort_i and start_i, including mid-sequence.
REQ-029 Reset values SHALL be trig_o=0, trap_enable_o=0, busy_o=0, done_o=0 and pulse_cnt_o=0; all latched configuration SHALL be 0.

Configuration
REQ-030 With macro OPTICAL_TRAP_SEQ_EXT_TRIG_EN defined, an input ext_trig_i (1 bit) SHALL exist and every trigger after PRE SHALL wait for a rising edge of ext_trig_i (edge-detected on clk_i) in place of the period count; trig_o SHALL follow that edge by 1 cycle.
REQ-031 Without OPTICAL_TRAP_SEQ_EXT_TRIG_EN, ext_trig_i SHALL NOT exist and timing SHALL be period-based only.

Structure
REQ-032 The FSM state enum and the minimum-period constant (2) SHALL reside in the shared pt_feedback package.
REQ-033 One sub-module, cycle_down_counter (load, decrement, zero flag; width COUNTER_WIDTH), SHALL be instantiated for both the PRE and WAIT counts.

Verification
REQ-034 pre=3, period=5, num=3, start at edge 10 -> trig_o high in cycles 14, 19 and 24; done_o in cycle 25; pulse_cnt_o=3.
REQ-035 period=0, num=2, pre=0 -> two triggers 2 cycles apart; never in consecutive cycles.
REQ-036 num=0 -> no trig_o; busy_o high 1 cycle; done_o in the following cycle.
REQ-037 abort_i asserted one cycle after the 2nd of 4 triggers -> IDLE next edge, no done_o, pulse_cnt_o=2.
REQ-038 rst_i asserted during WAIT together with start_i -> all outputs 0 next cycle; a start after reset is released runs normally.
REQ-039 With EXT_TRIG_EN, num=2, ext_trig_i rising edges at cycles 30 and 41 -> trig_o in cycles 31 and 42, then done_o.
